// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and encodings for the CPU pipeline
package cpu_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0;
    typedef enum logic [1:0] {FS_IDLE, FS_RUN, FS_FAULT} fetch_state_e;
    typedef enum logic [1:0] {FC_NONE = 2'b00, FC_RANGE = 2'b01, FC_ALIGN = 2'b10} fault_cause_e;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction memory bus between fetch unit and combinational memory
interface instr_fetch_unit_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
    logic [ADDR_W-1:0] pc_addr;
    logic [DATA_W-1:0] instr;
    modport master (output pc_addr, input instr);
    modport slave (input pc_addr, output instr);
endinterface

// File: rtl/instr_fetch_unit_ifid_reg.sv
// ifid_reg: IF/ID pipeline register with load, hold and flush (flush wins)
module ifid_reg import cpu_pkg::*; #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] instr_i,
    input  logic [ADDR_W-1:0] pc4_i,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] pc4_o,
    output logic              valid_o
);
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] pc4_q, pc4_d;
    logic              valid_q, valid_d;
    always_comb begin
        instr_d = flush_i ? DATA_W'(NOP_INSTR) : load_i ? instr_i : instr_q;
        pc4_d   = flush_i ? '0 : load_i ? pc4_i : pc4_q;
        valid_d = flush_i ? 1'b0 : load_i ? 1'b1 : valid_q;
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            instr_q <= DATA_W'(NOP_INSTR);
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end
    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: IF stage owning the PC, with stall, redirect and sticky fetch-fault trapping
module instr_fetch_unit import cpu_pkg::*; #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int MEM_WORDS = 32,
    parameter int CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    instr_fetch_unit_if.master imem,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic [DATA_W-1:0] ifid_instr_o,
    output logic [ADDR_W-1:0] ifid_pc4_o,
    output logic              ifid_valid_o,
    output logic              fetch_fault_o,
    output logic [1:0]        fault_cause_o,
    output logic [ADDR_W-1:0] fault_addr_o,
    output logic [CNT_W-1:0]  fetch_cnt_o
);
    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, fault_addr_q, fault_addr_d, pc_inc;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    fault_cause_e      cause_q, cause_d;
    logic              load, flush;
    assign pc_inc = pc_q + ADDR_W'(4);
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        cnt_d        = cnt_q;
        cause_d      = cause_q;
        fault_addr_d = fault_addr_q;
        load         = 1'b0;
        flush        = 1'b0;
        case (state_q)
            FS_IDLE: state_d = start_i ? FS_RUN : FS_IDLE;
            FS_RUN: begin
                if (redirect_i && redirect_pc_i[1:0] != 2'b00) begin
                    state_d      = FS_FAULT;
                    cause_d      = FC_ALIGN;
                    fault_addr_d = redirect_pc_i;
                    flush        = 1'b1;
                end else if (redirect_i) begin
                    pc_d  = redirect_pc_i;
                    flush = 1'b1;
                end else if (stall_i) begin
                    pc_d = pc_q;
                end else if (pc_q[ADDR_W-1:2] >= (ADDR_W-2)'(MEM_WORDS)) begin
                    // range is judged on the PC being fetched, so a bad redirect target traps one edge later
                    state_d      = FS_FAULT;
                    cause_d      = FC_RANGE;
                    fault_addr_d = pc_q;
                    flush        = 1'b1;
                end else begin
                    load  = 1'b1;
                    pc_d  = pc_inc;
                    cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                end
            end
            default: state_d = FS_FAULT;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= FS_IDLE;
            pc_q         <= RESET_PC;
            cnt_q        <= '0;
            cause_q      <= FC_NONE;
            fault_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            cnt_q        <= cnt_d;
            cause_q      <= cause_d;
            fault_addr_q <= fault_addr_d;
        end
    end
    ifid_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ifid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (load),
        .flush_i (flush),
        .instr_i (imem.instr),
        .pc4_i   (pc_inc),
        .instr_o (ifid_instr_o),
        .pc4_o   (ifid_pc4_o),
        .valid_o (ifid_valid_o)
    );
    assign imem.pc_addr  = pc_q;
    assign fetch_fault_o = (state_q == FS_FAULT);
    assign fault_cause_o = cause_q;
    assign fault_addr_o  = fault_addr_q;
    assign fetch_cnt_o   = cnt_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and randomized fetch scenarios checked against a behavioural model
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, stall = 1'b0, redir = 1'b0;
    logic [31:0] rpc = '0;
    logic [31:0] ifid_instr, ifid_pc4, fault_addr;
    logic        ifid_valid, fetch_fault;
    logic [1:0]  fault_cause;
    logic [3:0]  fetch_cnt;
    logic [31:0] mem [32];
    int          checks = 0, errors = 0;

    int          m_mode;
    logic [31:0] m_pc, m_instr, m_pc4, m_faddr;
    logic        m_valid, m_fault;
    logic [1:0]  m_cause;
    int          m_cnt;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) imem ();
    assign imem.instr = (imem.pc_addr < 32'h80) ? mem[imem.pc_addr[6:2]] : 32'hDEAD_BEEF;

    instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0), .MEM_WORDS(32), .CNT_W(4)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .imem          (imem),
        .stall_i       (stall),
        .redirect_i    (redir),
        .redirect_pc_i (rpc),
        .ifid_instr_o  (ifid_instr),
        .ifid_pc4_o    (ifid_pc4),
        .ifid_valid_o  (ifid_valid),
        .fetch_fault_o (fetch_fault),
        .fault_cause_o (fault_cause),
        .fault_addr_o  (fault_addr),
        .fetch_cnt_o   (fetch_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"}, imem.pc_addr, m_pc);
        chk({tag, ".valid"}, {31'b0, ifid_valid}, {31'b0, m_valid});
        chk({tag, ".instr"}, ifid_instr, m_instr);
        if (m_valid) chk({tag, ".pc4"}, ifid_pc4, m_pc4);
        chk({tag, ".fault"}, {31'b0, fetch_fault}, {31'b0, m_fault});
        chk({tag, ".cause"}, {30'b0, fault_cause}, {30'b0, m_cause});
        chk({tag, ".faddr"}, fault_addr, m_faddr);
        chk({tag, ".cnt"}, {28'b0, fetch_cnt}, 32'(m_cnt));
    endtask

    task automatic model_reset();
        m_mode = 0; m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0;
        m_fault = 0; m_cause = 0; m_faddr = 0; m_cnt = 0;
    endtask

    task automatic model_fault(input logic [1:0] cause, input logic [31:0] addr);
        m_mode = 2; m_fault = 1; m_cause = cause; m_faddr = addr;
        m_instr = 0; m_pc4 = 0; m_valid = 0;
    endtask

    // Expected effect of one rising edge, from the fetch rules
    task automatic model_edge(input logic st, input logic sl, input logic rd, input logic [31:0] t);
        if (m_mode == 0) begin
            if (st) m_mode = 1;
        end else if (m_mode == 1) begin
            if (rd && (t % 4) != 0) model_fault(2'b10, t);
            else if (rd) begin
                m_pc = t; m_instr = 0; m_pc4 = 0; m_valid = 0;
            end else if (sl) begin
            end else if (m_pc / 4 >= 32) model_fault(2'b01, m_pc);
            else begin
                m_instr = mem[m_pc / 4]; m_pc4 = m_pc + 4; m_valid = 1;
                m_pc = m_pc + 4;
                if (m_cnt < 15) m_cnt++;
            end
        end
    endtask

    task automatic step(input string tag, input logic st, input logic sl, input logic rd, input logic [31:0] t);
        @(negedge clk);
        start = st; stall = sl; redir = rd; rpc = t;
        model_edge(st, sl, rd, t);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b0; start = 0; stall = 0; redir = 0; rpc = 0;
        model_reset();
        #1;
        check_all(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        mem[0]  = 32'h0000_4020;
        mem[1]  = 32'h2009_000A;
        mem[10] = 32'h8D0B_0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        do_reset("reset2");

        step("idle", 0, 0, 0, 0);
        step("start", 1, 0, 0, 0);
        step("w0", 0, 0, 0, 0);
        step("w1", 0, 0, 0, 0);
        step("w2", 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("stall", 0, 1, 0, 0);
        step("w3", 0, 0, 0, 0);
        step("redir_stall", 0, 1, 1, 32'h28);
        step("w10", 0, 0, 0, 0);

        for (int i = 0; i < 150; i++)
            step("rand", $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0, 32'($urandom_range(0, 31)) * 4);

        do_reset("mid_reset");
        for (int i = 0; i < 3; i++) step("post_reset_idle", 0, 0, 0, 0);
        step("start2", 1, 0, 0, 0);
        step("to_78", 0, 0, 1, 32'h78);
        step("w30", 0, 0, 0, 0);
        step("w31", 0, 0, 0, 0);
        step("range", 0, 0, 0, 0);
        step("range_frozen", 1, 1, 1, 32'h10);
        step("range_frozen2", 1, 0, 0, 0);

        do_reset("reset3");
        step("start3", 1, 0, 0, 0);
        step("to_100", 0, 0, 1, 32'h100);
        step("range_100", 0, 0, 0, 0);

        do_reset("reset4");
        step("start4", 1, 0, 0, 0);
        step("w0b", 0, 0, 0, 0);
        step("misalign", 0, 0, 1, 32'h29);
        step("align_frozen", 1, 0, 1, 32'h10);
        step("align_frozen2", 1, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Initiator side of the instruction-memory interface and the IF stage of the pipelined CPU.
- Owns the PC and presents pc_addr_o to the combinational instruction memory, which returns instr_i in the same cycle.
- Captures each fetched word plus PC+4 into the IF/ID register for decode.
- Handles hazard stalls and branch redirects, and traps out-of-range or misaligned fetch addresses.

Parameters:
ADDR_W, 32, PC/address width
DATA_W, 32, instruction width
RESET_PC, 0, PC value after reset
MEM_WORDS, 32, instruction memory depth in words; legal byte addresses are 0 .. MEM_WORDS*4-4
CNT_W, 16, width of fetch counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
start_i  in  1  one-cycle pulse; leaves IDLE and begins fetching
pc_addr_o  out  ADDR_W  byte address to instruction memory (= pc_q)
instr_i  in  DATA_W  instruction word from memory, combinational from pc_addr_o
stall_i  in  1  hazard unit: hold PC and IF/ID
redirect_i  in  1  branch/jump taken; load redirect_pc_i, flush IF/ID
redirect_pc_i  in  ADDR_W  redirect target byte address
ifid_instr_o  out  DATA_W  IF/ID instruction
ifid_pc4_o  out  ADDR_W  IF/ID fetched PC + 4
ifid_valid_o  out  1  IF/ID holds a real instruction
fetch_fault_o  out  1  sticky fault flag
fault_cause_o  out  2  00 none, 01 out of range, 10 misaligned redirect
fault_addr_o  out  ADDR_W  offending address
fetch_cnt_o  out  CNT_W  instructions accepted into IF/ID, saturating

Behaviour:
- Reset (async, rst_i=0) forces:
  - pc_q=RESET_PC; state=IDLE.
  - ifid_instr_o=NOP (32'h0); ifid_pc4_o=0; ifid_valid_o=0.
  - fetch_fault_o=0; fault_cause_o=00; fault_addr_o=0; fetch_cnt_o=0.
  - Applies mid-operation identically. The first edge after release is ordinary.
- FSM states: IDLE, RUN, FAULT.
  - IDLE: pc_q held, IF/ID invalid. start_i=1 -> RUN. No fetch is captured on the start edge itself.
  - RUN, evaluated per rising edge in this priority order:
    1. redirect_i=1 with redirect_pc_i[1:0]!=0: FAULT, cause 10, fault_addr=redirect_pc_i, pc_q unchanged, IF/ID flushed.
    2. redirect_i=1 and aligned: pc_q<=redirect_pc_i, IF/ID<=NOP, valid=0. Overrides stall_i.
    3. stall_i=1: pc_q and IF/ID held unchanged, counter unchanged.
    4. (pc_q>>2) >= MEM_WORDS: FAULT, cause 01, fault_addr=pc_q, IF/ID<=NOP, valid=0, pc_q held.
    5. Otherwise: IF/ID<={instr_i, pc_q+4}, valid=1, pc_q<=pc_q+4 (mod 2^ADDR_W), fetch_cnt+1, saturating at all-ones.
  - FAULT: absorbing until reset. pc_q, IF/ID (invalid NOP) and counter frozen. start_i, stall_i and redirect_i are ignored.
- Latency: instruction at address A is visible on ifid_* one edge after pc_q=A with no stall or redirect.
- start_i while in RUN or FAULT: ignored.
- Out-of-range is checked on the current pc_q, not on a redirect target. An in-range-aligned redirect to an illegal address faults on the following edge.
- fault_* outputs are registered and change only on the edge entering FAULT.

Decomposition:
- Shared cpu_pkg holds:
  - NOP_INSTR constant (32'h0).
  - Fetch FSM state encodings.
  - Fault cause codes (FC_NONE, FC_RANGE, FC_ALIGN).
- Natural sub-module: ifid_reg, the IF/ID pipeline register with load, hold and flush controls and its valid bit. It is reused by later pipeline-register work.

Test Plan:
1. Reset, start_i pulse, memory word0=0x00004020, word1=0x2009000A, no stall -> ifid_instr 0x00004020/pc4 4, then 0x2009000A/pc4 8; fetch_cnt=2 after two edges.
2. stall_i=1 for 3 cycles at pc_q=0x0C -> pc_q stays 0x0C, ifid unchanged, fetch_cnt unchanged; after release the next capture is word3 with pc4 0x10.
3. redirect_i=1 and stall_i=1 together, redirect_pc_i=0x28 -> ifid_valid=0, ifid_instr=0. Next edge captures word10 (0x8D0B0000) with pc4 0x2C.
4. redirect_pc_i=0x29 -> fetch_fault_o=1, cause 10, fault_addr 0x29; later start_i and redirect_i have no effect.
5. Free-run from 0x78 with MEM_WORDS=32 -> word30 and word31 captured. At pc_q=0x80: fault cause 01, fault_addr 0x80, valid=0.
6. rst_i low mid-RUN between edges -> all outputs are reset values immediately. After release the unit stays in IDLE until start_i.
